// File: rtl/jtgng_spi_ioctl_slave.sv
// rtl/jtgng_spi_ioctl_slave.sv - SPI slave that turns host command frames into ROM download writes
// Optional feature macro: JTGNG_SPI_CHECKSUM_EN (16-bit sum of written bytes, read back with command 0x55)
module jtgng_spi_ioctl_slave (
   input  logic        clk_rom,
   input  logic        rst_n,
   input  logic        spi_sck,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic [21:0] ioctl_addr,
   output logic [7:0]  ioctl_data,
   output logic        ioctl_wr,
   output logic        downloading
);
   localparam logic [7:0] CMD_START = 8'h14;
   localparam logic [7:0] CMD_STOP  = 8'h15;
   localparam logic [7:0] CMD_DATA  = 8'h54;
`ifdef JTGNG_SPI_CHECKSUM_EN
   localparam logic [7:0] CMD_CSUM  = 8'h55;
`endif

   typedef enum logic [1:0] {IDLE, CMD, DATA, SINK} state_t;
   state_t state, state_nx;

   logic [1:0] sck_sync, cs_sync, mosi_sync;
   logic       sck_d, cs_d;
   logic [1:0] warm;
   logic       sck_s, cs_s, mosi_s;
   logic       sck_rise, sck_fall, cs_fall, active;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [7:0] rx_byte, last_byte;
   logic [7:0] tx_shift, tx_reload;
   logic       byte_done;
   logic       do_start, do_stop, do_write;
`ifdef JTGNG_SPI_CHECKSUM_EN
   logic       do_csum;
   logic [15:0] csum;
   logic [1:0]  csum_left;
`endif

   // Two-flop synchronizers plus one delay stage for edge detection; warm blocks
   // the fake CS edge seen while the synchronizer flushes after reset.
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= 2'b00;
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         sck_d     <= 1'b0;
         cs_d      <= 1'b1;
         warm      <= 2'd0;
      end else begin
         sck_sync  <= {sck_sync[0], spi_sck};
         cs_sync   <= {cs_sync[0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         sck_d     <= sck_sync[1];
         cs_d      <= cs_sync[1];
         if (warm != 2'd3) warm <= warm + 2'd1;
      end
   end

   assign sck_s     = sck_sync[1];
   assign cs_s      = cs_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign sck_rise  = sck_s & ~sck_d;
   assign sck_fall  = ~sck_s & sck_d;
   assign cs_fall   = ~cs_s & cs_d & (warm == 2'd3);
   assign active    = (state != IDLE) & ~cs_s;
   assign rx_byte   = {rx_shift, mosi_s};
   assign byte_done = active & sck_rise & (bit_cnt == 3'd7);

   // State register
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and command decode strobes
   always_comb begin
      state_nx = state;
      do_start = 1'b0;
      do_stop  = 1'b0;
      do_write = 1'b0;
`ifdef JTGNG_SPI_CHECKSUM_EN
      do_csum  = 1'b0;
`endif
      if (cs_s) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: if (cs_fall) state_nx = CMD;
            CMD: begin
               if (byte_done) begin
                  state_nx = SINK;
                  case (rx_byte)
                     CMD_START: do_start = 1'b1;
                     CMD_STOP:  do_stop  = 1'b1;
                     CMD_DATA:  state_nx = DATA;
`ifdef JTGNG_SPI_CHECKSUM_EN
                     CMD_CSUM:  do_csum  = 1'b1;
`endif
                     default: ;
                  endcase
               end
            end
            DATA: if (byte_done && downloading) do_write = 1'b1;
            default: ;
         endcase
      end
   end

   // Receive shifter; a partial byte is dropped whenever the frame ends
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= 3'd0;
         rx_shift  <= 7'd0;
         last_byte <= 8'd0;
      end else if (!active) begin
         bit_cnt <= 3'd0;
      end else if (sck_rise) begin
         rx_shift <= rx_byte[6:0];
         bit_cnt  <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) last_byte <= rx_byte;
      end
   end

   // ROM write port; the address is rewritten every cycle so it only changes on clear or post-strobe increment
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         ioctl_addr  <= 22'd0;
         ioctl_data  <= 8'd0;
         ioctl_wr    <= 1'b0;
         downloading <= 1'b0;
      end else begin
         ioctl_wr <= do_write;
         if (do_write) ioctl_data <= rx_byte;
         if (do_start)      ioctl_addr <= 22'd0;
         else if (ioctl_wr) ioctl_addr <= ioctl_addr + 22'd1;
         else               ioctl_addr <= ioctl_addr;
         if (do_start)     downloading <= 1'b1;
         else if (do_stop) downloading <= 1'b0;
      end
   end

`ifdef JTGNG_SPI_CHECKSUM_EN
   // Running sum of written bytes and the count of sum bytes still to be sent back
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         csum      <= 16'd0;
         csum_left <= 2'd0;
      end else begin
         if (do_start)      csum <= 16'd0;
         else if (do_write) csum <= csum + {8'd0, rx_byte};
         if (cs_s)          csum_left <= 2'd0;
         else if (do_csum)  csum_left <= 2'd2;
         else if (active && sck_fall && bit_cnt == 3'd0 && csum_left != 2'd0)
            csum_left <= csum_left - 2'd1;
      end
   end
`endif

   // Byte loaded into the transmit shifter at each byte boundary
   always_comb begin
      tx_reload = 8'd0;
      if (state == DATA) tx_reload = last_byte;
`ifdef JTGNG_SPI_CHECKSUM_EN
      else if (csum_left == 2'd2) tx_reload = csum[15:8];
      else if (csum_left == 2'd1) tx_reload = csum[7:0];
`endif
   end

   // Transmit shifter: status at frame start, then advanced on each SCK falling edge
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= 8'd0;
      end else if (cs_s) begin
         tx_shift <= 8'd0;
      end else if (cs_fall) begin
         tx_shift <= {downloading, 7'd0};
      end else if (active && sck_fall) begin
         tx_shift <= (bit_cnt == 3'd0) ? tx_reload : {tx_shift[6:0], 1'b0};
      end
   end

   assign spi_miso = tx_shift[7] & active;
endmodule

// File: tb/tb_jtgng_spi_ioctl_slave.sv
// tb/tb_jtgng_spi_ioctl_slave.sv - randomized frame-level bench for jtgng_spi_ioctl_slave
`timescale 1ns/1ps
module tb_jtgng_spi_ioctl_slave;
   localparam int HALF = 80;

   logic        clk_rom = 1'b0;
   logic        rst_n;
   logic        spi_sck, spi_cs_n, spi_mosi;
   logic        spi_miso;
   logic [21:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        downloading;

   int errors = 0;
   int checks = 0;

   logic [7:0]  frame_tx[$];
   logic [7:0]  frame_rx[$];
   logic [7:0]  exp_rx[$];
   logic [21:0] exp_a[$];
   logic [7:0]  exp_d[$];
   logic [21:0] obs_a[$];
   logic [7:0]  obs_d[$];

   logic        m_dl;
   logic [21:0] m_addr;
   logic [15:0] m_csum;
   logic        wr_prev = 1'b0;
   logic [21:0] mon_a;
   logic [7:0]  mon_d;

   jtgng_spi_ioctl_slave dut (
      .clk_rom(clk_rom), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .ioctl_addr(ioctl_addr),
      .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .downloading(downloading)
   );

   always #5 clk_rom = ~clk_rom;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every write strobe must match the next expected write and last one cycle
   always @(negedge clk_rom) begin
      if (ioctl_wr === 1'b1) begin
         obs_a.push_back(ioctl_addr);
         obs_d.push_back(ioctl_data);
         chk("wr_single_cycle", {31'd0, wr_prev}, 32'd0);
         if (exp_a.size() == 0) begin
            chk("wr_unexpected", {10'd0, ioctl_addr}, 32'hFFFFFFFF);
         end else begin
            mon_a = exp_a.pop_front();
            mon_d = exp_d.pop_front();
            chk("wr_addr", {10'd0, ioctl_addr}, {10'd0, mon_a});
            chk("wr_data", {24'd0, ioctl_data}, {24'd0, mon_d});
         end
      end
      wr_prev = ioctl_wr;
   end

   task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
      r = 8'd0;
      for (int k = 7; k > 7 - nbits; k--) begin
         spi_mosi = b[k];
         #HALF;
         r[k] = spi_miso;
         spi_sck = 1'b1;
         #HALF;
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_frame(input int partial);
      logic [7:0] r;
      frame_rx.delete();
      spi_cs_n = 1'b0;
      #(2*HALF);
      foreach (frame_tx[i]) begin
         send_byte(frame_tx[i], 8, r);
         frame_rx.push_back(r);
      end
      if (partial > 0) send_byte(8'($urandom), partial, r);
      #HALF;
      spi_cs_n = 1'b1;
      #(3*HALF);
   endtask

   // Frame-level reference: what each command means for state, writes and MISO bytes
   task automatic model_frame();
      logic [7:0] prev;
      int mode;
      exp_rx.delete();
      exp_rx.push_back({m_dl, 7'd0});
      mode = 0;
      case (frame_tx[0])
         8'h14: begin m_dl = 1'b1; m_addr = 22'd0; m_csum = 16'd0; end
         8'h15: m_dl = 1'b0;
         8'h54: mode = 1;
`ifdef JTGNG_SPI_CHECKSUM_EN
         8'h55: mode = 2;
`endif
         default: ;
      endcase
      prev = frame_tx[0];
      for (int i = 1; i < frame_tx.size(); i++) begin
         if (mode == 1) begin
            exp_rx.push_back(prev);
            if (m_dl) begin
               exp_a.push_back(m_addr);
               exp_d.push_back(frame_tx[i]);
               m_addr = (m_addr + 22'd1) % 22'h3FFFFF == 0 && m_addr == 22'h3FFFFE ? 22'h3FFFFF : 22'((32'(m_addr) + 1) % 32'h400000);
               m_csum = m_csum + 16'(frame_tx[i]);
            end
         end else if (mode == 2 && i == 1) exp_rx.push_back(m_csum[15:8]);
         else if (mode == 2 && i == 2)     exp_rx.push_back(m_csum[7:0]);
         else                              exp_rx.push_back(8'd0);
         prev = frame_tx[i];
      end
   endtask

   task automatic run_frame(input int partial);
      model_frame();
      spi_frame(partial);
      foreach (exp_rx[i]) chk($sformatf("miso_byte%0d", i), {24'd0, frame_rx[i]}, {24'd0, exp_rx[i]});
      chk("downloading", {31'd0, downloading}, {31'd0, m_dl});
      chk("addr_after_frame", {10'd0, ioctl_addr}, {10'd0, m_addr});
      chk("writes_pending", exp_a.size(), 0);
   endtask

   initial begin
      logic [7:0] r;
      int n, c;
      rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
      m_dl = 1'b0; m_addr = 22'd0; m_csum = 16'd0;
      repeat (5) @(negedge clk_rom);
      chk("rst_wr", {31'd0, ioctl_wr}, 0);
      chk("rst_addr", {10'd0, ioctl_addr}, 0);
      chk("rst_data", {24'd0, ioctl_data}, 0);
      chk("rst_dl", {31'd0, downloading}, 0);
      chk("rst_miso", {31'd0, spi_miso}, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_rom);

      // Basic download
      frame_tx = '{8'h14}; run_frame(0);
      obs_a.delete(); obs_d.delete();
      frame_tx = '{8'h54, 8'hA5, 8'h5A, 8'hFF}; run_frame(0);
      chk("lit_status", {24'd0, frame_rx[0]}, 32'h80);
      chk("lit_echo", {24'd0, frame_rx[1]}, 32'h54);
      chk("lit_nwr", obs_a.size(), 3);
      chk("lit_a0", {10'd0, obs_a[0]}, 0);   chk("lit_d0", {24'd0, obs_d[0]}, 32'hA5);
      chk("lit_a1", {10'd0, obs_a[1]}, 1);   chk("lit_d1", {24'd0, obs_d[1]}, 32'h5A);
      chk("lit_a2", {10'd0, obs_a[2]}, 2);   chk("lit_d2", {24'd0, obs_d[2]}, 32'hFF);
      chk("lit_dl", {31'd0, downloading}, 1);

      // Data while not downloading is discarded
      frame_tx = '{8'h15}; run_frame(0);
      frame_tx = '{8'h54, 8'h01, 8'h77, 8'hC0}; run_frame(0);
      chk("lit_addr_kept", {10'd0, ioctl_addr}, 3);

      // CS raised mid-byte
      frame_tx = '{8'h14}; run_frame(0);
      frame_tx = '{8'h54, 8'h11}; run_frame(0);
      frame_tx = '{8'h54}; run_frame(5);
      obs_a.delete();
      frame_tx = '{8'h54, 8'h22}; run_frame(0);
      chk("lit_after_partial", {10'd0, obs_a[0]}, 1);

      // Randomized frames
      for (int f = 0; f < 25; f++) begin
         c = $urandom_range(0, 5);
         frame_tx.delete();
         case (c)
            0: frame_tx.push_back(8'h14);
            1: frame_tx.push_back(8'h15);
            4: frame_tx.push_back(8'h55);
            5: frame_tx.push_back(8'($urandom));
            default: frame_tx.push_back(8'h54);
         endcase
         n = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) frame_tx.push_back(8'($urandom));
         run_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
      end

      // Address wrap, with the address preloaded by a backdoor
      frame_tx = '{8'h14}; run_frame(0);
      force dut.ioctl_addr = 22'h3FFFFF;
      repeat (3) @(negedge clk_rom);
      release dut.ioctl_addr;
      m_addr = 22'h3FFFFF;
      obs_a.delete();
      frame_tx = '{8'h54, 8'($urandom), 8'($urandom)}; run_frame(0);
      chk("lit_wrap_hi", {10'd0, obs_a[0]}, 32'h3FFFFF);
      chk("lit_wrap_lo", {10'd0, obs_a[1]}, 0);

      // Checksum readback (unknown command when the feature is absent)
      frame_tx = '{8'h14}; run_frame(0);
      frame_tx = '{8'h54, 8'h01, 8'h02, 8'hFF}; run_frame(0);
      frame_tx = '{8'h55, 8'h00, 8'h00}; run_frame(0);
`ifdef JTGNG_SPI_CHECKSUM_EN
      chk("lit_csum_hi", {24'd0, frame_rx[1]}, 32'h01);
      chk("lit_csum_lo", {24'd0, frame_rx[2]}, 32'h02);
`else
      chk("lit_csum_absent", {16'd0, frame_rx[1], frame_rx[2]}, 0);
`endif

      // Reset mid-burst, then CS stays low across the release
      frame_tx = '{8'h54, 8'h3C, 8'hC3}; run_frame(0);
      spi_cs_n = 1'b0;
      #(2*HALF);
      send_byte(8'h54, 8, r);
      send_byte(8'h77, 4, r);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_addr", {10'd0, ioctl_addr}, 0);
      chk("midrst_data", {24'd0, ioctl_data}, 0);
      chk("midrst_wr", {31'd0, ioctl_wr}, 0);
      chk("midrst_dl", {31'd0, downloading}, 0);
      chk("midrst_miso", {31'd0, spi_miso}, 0);
      #20 rst_n = 1'b1;
      m_dl = 1'b0; m_addr = 22'd0; m_csum = 16'd0;
      send_byte(8'h99, 8, r);
      chk("postrst_miso_a", {24'd0, r}, 0);
      send_byte(8'h14, 8, r);
      chk("postrst_miso_b", {24'd0, r}, 0);
      #HALF spi_cs_n = 1'b1;
      #(3*HALF);
      chk("postrst_dl", {31'd0, downloading}, 0);
      frame_tx = '{8'h15}; run_frame(0);
      chk("lit_final_dl", {31'd0, downloading}, 0);

      #1000;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jtgng_spi_ioctl_slave.md
JTGNG_SPI_IOCTL_SLAVE -- requirements
Module: jtgng_spi_ioctl_slave

Interface
REQ-001 SHALL have port clk_rom, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port spi_sck, input, 1, SPI clock from external host, mode 0, asynchronous to clk_rom, at most clk_rom/8.
REQ-004 SHALL have port spi_cs_n, input, 1, active-low chip select; framing for commands.
REQ-005 SHALL have port spi_mosi, input, 1, host-to-block serial data, MSB first.
REQ-006 SHALL have port spi_miso, output, 1, block-to-host serial data, MSB first.
REQ-007 SHALL have port ioctl_addr, output, 22, ROM byte address of current write.
REQ-008 SHALL have port ioctl_data, output, 8, ROM byte for current write.
REQ-009 SHALL have port ioctl_wr, output, 1, single-cycle write strobe.
REQ-010 SHALL have port downloading, output, 1, high while a ROM download session is open.

Function
REQ-011 SHALL pass spi_sck, spi_cs_n and spi_mosi through 2-flop synchronizers, then detect SCK rising/falling edges on the synchronized copies.
REQ-012 SHALL sample MOSI on each synchronized SCK rising edge while synchronized CS is low, shifting MSB first; a byte completes on the 8th rising edge.
REQ-013 SHALL use states IDLE, CMD, DATA, SINK; CS high forces IDLE; CS falling edge: IDLE -> CMD.
REQ-014 In CMD the first completed byte is the command: 0x14 -> set downloading, clear ioctl_addr to 0, go SINK; 0x15 -> clear downloading, go SINK; 0x54 -> go DATA; any other value -> SINK.
REQ-015 In DATA, each completed byte while downloading=1 SHALL drive ioctl_data with the byte and pulse ioctl_wr for exactly one cycle in the cycle after completion, with ioctl_addr holding that byte's address.
REQ-016 ioctl_addr SHALL increment by 1 in the cycle after each ioctl_wr pulse, wrapping 0x3FFFFF -> 0x000000.
REQ-017 DATA bytes received while downloading=0 SHALL be discarded with no ioctl_wr.
REQ-018 SINK SHALL discard all further bytes until CS rises.
REQ-019 CS rising mid-byte SHALL discard the partial byte and clear the bit counter; no ioctl_wr results.
REQ-020 0x15 while downloading=0 and 0x14 while downloading=1 SHALL be legal; 0x14 re-clears ioctl_addr.
REQ-021 spi_miso SHALL update on synchronized SCK falling edges; during the command byte it carries status {downloading, 7'b0}; in DATA it carries the previously completed byte; 0 whenever CS is high.
REQ-022 ioctl_addr and ioctl_data SHALL hold their values between strobes.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, bit counter 0, ioctl_addr 0, ioctl_data 0, ioctl_wr 0, downloading 0, spi_miso 0, synchronizers to idle levels (cs high, sck low).
REQ-024 Release of rst_n during an active CS-low transfer SHALL keep the block in IDLE until the next CS falling edge.

Configuration
REQ-025 With macro JTGNG_SPI_CHECKSUM_EN defined, the block SHALL keep a 16-bit wrapping sum of all written bytes, cleared by 0x14; command 0x55 returns the sum on spi_miso, high byte then low byte, in the two following bytes, then SINK.
REQ-026 Without JTGNG_SPI_CHECKSUM_EN, no checksum logic SHALL exist and 0x55 SHALL be treated as an unknown command.

Verification
REQ-027 Frame 0x14; frame 0x54,0xA5,0x5A,0xFF -> three ioctl_wr pulses, addr 0/1/2, data 0xA5/0x5A/0xFF, downloading=1.
REQ-028 0x54 followed by bytes with downloading=0 -> no ioctl_wr, ioctl_addr unchanged.
REQ-029 Start download, force addr to 0x3FFFFF via 4M-byte burst (or backdoor) -> next write at 0x3FFFFF, following write at 0x000000.
REQ-030 CS raised after 5 bits of a DATA byte -> no ioctl_wr; next full frame writes normally at the unchanged address.
REQ-031 rst_n pulsed low mid-burst -> all outputs 0 immediately; subsequent frame 0x15 leaves downloading=0.
REQ-032 With JTGNG_SPI_CHECKSUM_EN: 0x14, data 0x01,0x02,0xFF, then 0x55 -> MISO returns 0x01 then 0x02 (sum 0x0102).
